// File: rtl/cga_intr_level_arb_pkg.sv
// Shared types and widths for the CGA interrupt level arbiter.
package cga_intr_pkg;

  localparam int unsigned LVL_W = 4;
  localparam int unsigned NLVL  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACK   = 2'd2,
    BLANK = 2'd3
  } arb_state_t;

  typedef logic [LVL_W-1:0] lvl_t;

endpackage

// File: rtl/cga_intr_level_arb_if.sv
// Request/ack bundle between the IRQ request bits, the arbiter and the microprogram.
interface cga_intr_level_arb_if #(
  parameter int unsigned NLVL = 16
);
  import cga_intr_pkg::*;

  logic [NLVL-1:0] inr_i;
  logic [NLVL-1:0] pie_i;
  lvl_t            pil_i;
  logic            ion_i;
  logic            ack_i;
  logic            irq_o;
  lvl_t            lvl_o;
  logic [NLVL-1:0] clr_o;
  logic            busy_o;

  modport slave (
    input  inr_i, pie_i, pil_i, ion_i, ack_i,
    output irq_o, lvl_o, clr_o, busy_o
  );

  modport master (
    output inr_i, pie_i, pil_i, ion_i, ack_i,
    input  irq_o, lvl_o, clr_o, busy_o
  );
endinterface

// File: rtl/cga_intr_level_arb_prio_enc.sv
// Highest-set-bit priority encoder; purely combinational.
module cga_intr_prio_enc #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] vec_i,
  output logic         valid_c,
  output logic [W-1:0] idx_c
);

  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec_i[i]) idx_c = W'(i);
    end
    valid_c = |vec_i;
  end

endmodule

// File: rtl/cga_intr_level_arb.sv
// Interrupt level arbiter: masks pending levels, requests the highest one above PIL, clears on ack.
// Optional CGA_INTR_ARB_SYNC_EN adds a 2-flop synchronizer on inr_i ahead of the pending register.
module cga_intr_level_arb #(
  parameter int unsigned NLVL      = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input logic                  sysclk,
  input logic                  sys_rst,
  cga_intr_level_arb_if.slave  bus
);
  import cga_intr_pkg::*;

  localparam int unsigned CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYC - 1);

  logic [NLVL-1:0] inr_s;
  logic [NLVL-1:0] pend_q, pend_d;
  logic            pend_vld;
  lvl_t            best;
  logic            qual;

  arb_state_t      state_q, state_d;
  logic            irq_q, irq_d;
  lvl_t            lvl_q, lvl_d;
  logic [NLVL-1:0] clr_q, clr_d;
  logic            busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef CGA_INTR_ARB_SYNC_EN
  logic [NLVL-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.inr_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign inr_s = sync2_q;
`else
  assign inr_s = bus.inr_i;
`endif

  // Level 0 is the background level and can never raise a request.
  always_comb begin
    pend_d    = inr_s & bus.pie_i;
    pend_d[0] = 1'b0;
  end

  cga_intr_prio_enc #(
    .N (NLVL),
    .W (LVL_W)
  ) u_prio_enc (
    .vec_i   (pend_q),
    .valid_c (pend_vld),
    .idx_c   (best)
  );

  assign qual = bus.ion_i & pend_vld & (best > bus.pil_i);

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    lvl_d   = lvl_q;
    clr_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (qual) begin
          state_d = REQ;
          irq_d   = 1'b1;
          lvl_d   = best;
        end
      end
      REQ: begin
        // Ack takes precedence over a withdraw seen in the same cycle.
        if (bus.ack_i) begin
          state_d      = ACK;
          clr_d[lvl_q] = 1'b1;
        end else if (qual) begin
          irq_d = 1'b1;
          lvl_d = best;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
      BLANK: begin
        if (cnt_q == CNT_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ACK) || (state_d == BLANK);
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      pend_q  <= '0;
      state_q <= IDLE;
      irq_q   <= 1'b0;
      lvl_q   <= '0;
      clr_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
      irq_q   <= irq_d;
      lvl_q   <= lvl_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.irq_o  = irq_q;
  assign bus.lvl_o  = lvl_q;
  assign bus.clr_o  = clr_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_cga_intr_level_arb.sv
// Bench for cga_intr_level_arb: directed vector table, latency/blank sequence, randomized run vs model.
module tb_cga_intr_level_arb;
  import cga_intr_pkg::*;

  localparam int unsigned BC = 2;
`ifdef CGA_INTR_ARB_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic sysclk  = 1'b0;
  logic sys_rst = 1'b1;

  cga_intr_level_arb_if #(.NLVL(16)) bus ();

  cga_intr_level_arb #(.NLVL(16), .BLANK_CYC(BC)) dut (
    .sysclk  (sysclk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: request/quiet-window view of the arbiter, one update per clock edge.
  int m_irq, m_lvl, m_clr, m_busy, m_quiet, m_pend, m_pipe0, m_pipe1;

  function automatic int highest(input int v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int  best;
    bit  qual;
    int  inr_eff;
    best = highest(m_pend);
    qual = bus.ion_i && (m_pend != 0) && (best > int'(bus.pil_i));
    if (sys_rst) begin
      m_irq = 0; m_lvl = 0; m_clr = 0; m_busy = 0; m_quiet = 0;
      m_pend = 0; m_pipe0 = 0; m_pipe1 = 0;
    end else begin
      m_clr = 0;
      if (m_quiet > 0) begin
        m_quiet--;
        m_irq  = 0;
        m_busy = (m_quiet > 0) ? 1 : 0;
      end else if (m_irq == 1) begin
        if (bus.ack_i) begin
          m_clr   = 1 << m_lvl;
          m_irq   = 0;
          m_quiet = int'(BC) + 1;
          m_busy  = 1;
        end else if (!qual) begin
          m_irq = 0;
        end else begin
          m_lvl = best;
        end
      end else if (qual) begin
        m_irq = 1;
        m_lvl = best;
      end
`ifdef CGA_INTR_ARB_SYNC_EN
      inr_eff = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = int'(bus.inr_i);
`else
      inr_eff = int'(bus.inr_i);
`endif
      m_pend = inr_eff & int'(bus.pie_i) & 32'hFFFE;
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    model_edge();
    #1;
  endtask

  task automatic compare_model(input int cyc);
    check($sformatf("rnd%0d irq", cyc),  32'(bus.irq_o),  32'(m_irq));
    check($sformatf("rnd%0d clr", cyc),  32'(bus.clr_o),  32'(m_clr));
    check($sformatf("rnd%0d busy", cyc), 32'(bus.busy_o), 32'(m_busy));
    if (m_irq == 1 || m_clr != 0)
      check($sformatf("rnd%0d lvl", cyc), 32'(bus.lvl_o), 32'(m_lvl));
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] inr;
    logic [15:0] pie;
    logic [3:0]  pil;
    logic        ion;
    logic        ack;
    logic        irq;
    logic [3:0]  lvl;
    logic [15:0] clr;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [15:0] inr, input logic [15:0] pie,
                              input logic [3:0] pil, input logic ion, input logic ack,
                              input logic irq, input logic [3:0] lvl, input logic [15:0] clr,
                              input logic busy);
    vec_t v;
    v.rst = rst; v.inr = inr; v.pie = pie; v.pil = pil; v.ion = ion; v.ack = ack;
    v.irq = irq; v.lvl = lvl; v.clr = clr; v.busy = busy;
    return v;
  endfunction

  vec_t tbl [34];

  initial begin
    logic [15:0] inr_r;
    int          busy_n;

    bus.inr_i = '0; bus.pie_i = 16'hFFFF; bus.pil_i = '0; bus.ion_i = 1'b1; bus.ack_i = 1'b0;

`ifndef CGA_INTR_ARB_SYNC_EN
    // Rows: inputs applied for one edge, then the expected registered outputs after that edge.
    tbl[0]  = mk(1, 16'h0000, 16'hFFFF, 4'd3,  1, 0,  0, 4'd0,  16'h0000, 0);
    tbl[1]  = mk(0, 16'h0020, 16'hFFFF, 4'd3,  1, 0,  0, 4'd0,  16'h0000, 0);
    tbl[2]  = mk(0, 16'h0020, 16'hFFFF, 4'd3,  1, 0,  1, 4'd5,  16'h0000, 0);
    tbl[3]  = mk(0, 16'h2020, 16'hFFFF, 4'd3,  1, 0,  1, 4'd5,  16'h0000, 0);
    tbl[4]  = mk(0, 16'h2020, 16'hFFFF, 4'd3,  1, 0,  1, 4'd13, 16'h0000, 0);
    tbl[5]  = mk(0, 16'h2020, 16'hFFFF, 4'd3,  1, 1,  0, 4'd13, 16'h2000, 1);
    tbl[6]  = mk(0, 16'h0020, 16'hFFFF, 4'd3,  1, 0,  0, 4'd13, 16'h0000, 1);
    tbl[7]  = mk(0, 16'h0020, 16'hFFFF, 4'd3,  1, 0,  0, 4'd13, 16'h0000, 1);
    tbl[8]  = mk(0, 16'h0020, 16'hFFFF, 4'd3,  1, 0,  0, 4'd13, 16'h0000, 0);
    tbl[9]  = mk(0, 16'h0020, 16'hFFFF, 4'd3,  1, 0,  1, 4'd5,  16'h0000, 0);
    tbl[10] = mk(0, 16'h0010, 16'hFFFF, 4'd4,  1, 0,  1, 4'd5,  16'h0000, 0);
    tbl[11] = mk(0, 16'h0010, 16'hFFFF, 4'd4,  1, 0,  0, 4'd5,  16'h0000, 0);
    tbl[12] = mk(0, 16'h0010, 16'hFFFF, 4'd4,  1, 0,  0, 4'd5,  16'h0000, 0);
    tbl[13] = mk(0, 16'h0010, 16'hFFFF, 4'd2,  1, 0,  1, 4'd4,  16'h0000, 0);
    tbl[14] = mk(0, 16'h0010, 16'hFFFF, 4'd2,  0, 0,  0, 4'd4,  16'h0000, 0);
    tbl[15] = mk(0, 16'h0010, 16'hFFFF, 4'd2,  0, 1,  0, 4'd4,  16'h0000, 0);
    tbl[16] = mk(0, 16'h0010, 16'hFFFF, 4'd2,  1, 1,  1, 4'd4,  16'h0000, 0);
    tbl[17] = mk(0, 16'h0200, 16'hFFFF, 4'd2,  1, 0,  1, 4'd4,  16'h0000, 0);
    tbl[18] = mk(0, 16'h0200, 16'hFFFF, 4'd2,  1, 0,  1, 4'd9,  16'h0000, 0);
    tbl[19] = mk(0, 16'h0200, 16'hFDFF, 4'd2,  0, 1,  0, 4'd9,  16'h0200, 1);
    tbl[20] = mk(0, 16'h0001, 16'hFFFF, 4'd0,  1, 0,  0, 4'd9,  16'h0000, 1);
    tbl[21] = mk(0, 16'h0001, 16'hFFFF, 4'd0,  1, 0,  0, 4'd9,  16'h0000, 1);
    tbl[22] = mk(0, 16'h0001, 16'hFFFF, 4'd0,  1, 0,  0, 4'd9,  16'h0000, 0);
    tbl[23] = mk(0, 16'h0001, 16'hFFFF, 4'd0,  1, 0,  0, 4'd9,  16'h0000, 0);
    tbl[24] = mk(0, 16'h0001, 16'hFFFF, 4'd0,  1, 0,  0, 4'd9,  16'h0000, 0);
    tbl[25] = mk(0, 16'h0100, 16'hFFFF, 4'd0,  1, 0,  0, 4'd9,  16'h0000, 0);
    tbl[26] = mk(0, 16'h0100, 16'hFFFF, 4'd0,  1, 0,  1, 4'd8,  16'h0000, 0);
    tbl[27] = mk(0, 16'h0100, 16'hFFFF, 4'd0,  1, 1,  0, 4'd8,  16'h0100, 1);
    tbl[28] = mk(1, 16'h0100, 16'hFFFF, 4'd0,  1, 0,  0, 4'd0,  16'h0000, 0);
    tbl[29] = mk(0, 16'h0100, 16'hFFFF, 4'd0,  1, 0,  0, 4'd0,  16'h0000, 0);
    tbl[30] = mk(0, 16'h0100, 16'hFFFF, 4'd0,  1, 0,  1, 4'd8,  16'h0000, 0);
    tbl[31] = mk(0, 16'h8100, 16'hFFFF, 4'd15, 1, 0,  0, 4'd8,  16'h0000, 0);
    tbl[32] = mk(0, 16'h8100, 16'hFFFF, 4'd15, 1, 0,  0, 4'd8,  16'h0000, 0);
    tbl[33] = mk(0, 16'h8100, 16'hFFFF, 4'd14, 1, 0,  1, 4'd15, 16'h0000, 0);

    for (int i = 0; i < 34; i++) begin
      sys_rst   = tbl[i].rst;
      bus.inr_i = tbl[i].inr;
      bus.pie_i = tbl[i].pie;
      bus.pil_i = tbl[i].pil;
      bus.ion_i = tbl[i].ion;
      bus.ack_i = tbl[i].ack;
      step();
      check($sformatf("row%0d irq", i),  32'(bus.irq_o),  32'(tbl[i].irq));
      check($sformatf("row%0d clr", i),  32'(bus.clr_o),  32'(tbl[i].clr));
      check($sformatf("row%0d busy", i), 32'(bus.busy_o), 32'(tbl[i].busy));
      if (tbl[i].irq || tbl[i].clr != 0 || tbl[i].rst)
        check($sformatf("row%0d lvl", i), 32'(bus.lvl_o), 32'(tbl[i].lvl));
    end
`endif

    // Request latency from inr_i, then the length of the busy window after an ack.
    sys_rst = 1'b1; bus.inr_i = '0; bus.pie_i = 16'hFFFF; bus.pil_i = '0;
    bus.ion_i = 1'b1; bus.ack_i = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    bus.inr_i = 16'h0040;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check($sformatf("latency edge%0d irq", k), 32'(bus.irq_o), 32'(k == LAT));
    end
    check("latency lvl", 32'(bus.lvl_o), 32'd6);
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    bus.inr_i = '0;
    check("ack clr", 32'(bus.clr_o), 32'h0040);
    busy_n = bus.busy_o ? 1 : 0;
    for (int k = 0; k < 10 && bus.busy_o; k++) begin
      step();
      if (bus.busy_o) busy_n++;
    end
    check("busy window", 32'(busy_n), 32'(BC + 1));

    // Randomized traffic; request bits are cleared when the model says clr fired.
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    inr_r = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0)
        inr_r = inr_r | (16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535)));
      bus.inr_i = inr_r;
      bus.pie_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'hFFFF;
      if ($urandom_range(0, 7) == 0) bus.pil_i = 4'($urandom_range(0, 15));
      bus.ion_i = ($urandom_range(0, 15) != 0);
      bus.ack_i = ($urandom_range(0, 2) == 0);
      sys_rst   = ($urandom_range(0, 99) == 0);
      step();
      compare_model(c);
      if (m_clr != 0) inr_r = inr_r & ~16'(m_clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
